led_write_arbiter: RTL and testbench

//  Shares the 9-bit green-LED PIO output register between NUM_REQ on-chip requesters
//  (e.g. firewall drop/pass indicators and link status). Each requester offers an LED

---
 rtl/led_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_led_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_write_arbiter.sv
// Round-robin arbiter that shares the LED PIO output register between NUM_REQ requesters.
// Optional readback verify cycle and sticky error flag: define LEDARB_READBACK_EN.
module led_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int OWN_W       = 2,
    parameter int LED_W       = 9,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LED_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic [1:0]               m_address,
    output logic                     m_chipselect,
    output logic                     m_write_n,
    output logic [31:0]              m_writedata,
    input  logic [31:0]              m_readdata,
    output logic                     busy,
    output logic [OWN_W-1:0]         owner,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        VERIFY,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [OWN_W-1:0]   last_grant;
    logic [OWN_W-1:0]   winner;
    logic [OWN_W-1:0]   cand;
    logic               any_req;
    logic [LED_W-1:0]   win_word;

`ifdef LEDARB_READBACK_EN
    logic [LED_W-1:0]   word;
`else
    logic               unused_readdata;
    assign unused_readdata = ^m_readdata;
`endif

    // First set request bit searching upward from last_grant+1, wrapping at NUM_REQ.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = OWN_W'((32'(last_grant) + k) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == OWN_W'(i)) begin
                win_word = req_data[i*LED_W +: LED_W];
            end
        end
    end

    // Outputs are assigned from the next state so each one lines up with its state cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            last_grant   <= OWN_W'(NUM_REQ - 1);
            ack          <= '0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
            busy         <= 1'b0;
            owner        <= '0;
            err          <= 1'b0;
`ifdef LEDARB_READBACK_EN
            word         <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= WRITE;
                        owner        <= winner;
                        last_grant   <= winner;
                        ack[winner]  <= 1'b1;
                        busy         <= 1'b1;
                        m_address    <= '0;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= 32'(win_word);
`ifdef LEDARB_READBACK_EN
                        word         <= win_word;
`endif
                    end
                end
                WRITE: begin
`ifdef LEDARB_READBACK_EN
                    state     <= VERIFY;
                    m_write_n <= 1'b1;
`else
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    m_writedata  <= '0;
                    if (HOLD_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
`endif
                end
                VERIFY: begin
`ifdef LEDARB_READBACK_EN
                    if (m_readdata != 32'(word)) begin
                        err <= 1'b1;
                    end
`endif
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    m_writedata  <= '0;
                    if (HOLD_CYCLES == 0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_write_arbiter.sv
// Scoreboard bench for led_write_arbiter with HOLD_CYCLES=4; expected writes are queued
// as requests are raised and matched against each PIO write cycle by a monitor.
module tb_led_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OWN_W   = 2;
    localparam int LED_W   = 9;
    localparam int HOLD    = 4;
`ifdef LEDARB_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int GAP      = 2 + HOLD + RB;
    localparam int BUSY_LEN = 1 + RB + HOLD;

    logic                     clk;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [1:0]               m_address;
    logic                     m_chipselect;
    logic                     m_write_n;
    logic [31:0]              m_writedata;
    logic [31:0]              m_readdata;
    logic                     busy;
    logic [OWN_W-1:0]         owner;
    logic                     err;

    led_write_arbiter #(
        .NUM_REQ(NUM_REQ),
        .OWN_W(OWN_W),
        .LED_W(LED_W),
        .HOLD_CYCLES(HOLD),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .m_address(m_address),
        .m_chipselect(m_chipselect),
        .m_write_n(m_write_n),
        .m_writedata(m_writedata),
        .m_readdata(m_readdata),
        .busy(busy),
        .owner(owner),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: stores writes, optionally returns a corrupted readback.
    logic [31:0] slave_reg = '0;
    bit          slave_broken = 1'b0;
    always @(posedge clk) if (m_chipselect && !m_write_n) slave_reg <= m_writedata;
    assign m_readdata = slave_broken ? 32'h0 : slave_reg;

    typedef struct {
        int         idx;
        logic [8:0] word;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   log_owner[$];
    int   log_cyc[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n === 1'b1 && ack !== '0) begin
            vectors++;
            if ($countones(ack) != 1 || m_chipselect !== 1'b1 || m_write_n !== 1'b0) begin
                miscompares++;
                $display("FAIL ack_onehot: ack=%b cs=%b write_n=%b, required one ack bit inside a write cycle",
                         ack, m_chipselect, m_write_n);
            end
        end
        if (reset_n === 1'b1 && m_chipselect === 1'b1 && m_write_n === 1'b0) begin
            log_owner.push_back(int'(owner));
            log_cyc.push_back(cyc);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: owner=%0d data=%h, required no write", owner, m_writedata);
            end else begin
                e = sb.pop_front();
                if (owner !== OWN_W'(e.idx) || ack !== 4'(1 << e.idx) ||
                    m_writedata !== {23'b0, e.word} || m_address !== 2'b00) begin
                    miscompares++;
                    $display("FAIL write: owner=%0d ack=%b data=%h addr=%0d, required owner=%0d ack=%b data=%h addr=0",
                             owner, ack, m_writedata, m_address, e.idx, 4'(1 << e.idx), {23'b0, e.word});
                end
            end
        end
    end

    task automatic tick(input bit drop);
        @(negedge clk);
        #1;
        if (drop) req = req & ~ack;
    endtask

    task automatic reset_dut();
        req     = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        log_owner.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        req      = '0;
        req_data = '0;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ack !== 4'b0 || m_address !== 2'b0 || m_chipselect !== 1'b0 || m_write_n !== 1'b1 ||
            m_writedata !== 32'h0 || busy !== 1'b0 || owner !== 2'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: ack=%b addr=%0d cs=%b wn=%b wd=%h busy=%b owner=%0d err=%b, required 0,0,0,1,0,0,0,0",
                     ack, m_address, m_chipselect, m_write_n, m_writedata, busy, owner, err);
        end
        reset_dut();
    endtask

    task automatic test_single();
        int busy_cnt;
        int ack_cnt;
        reset_dut();
        req_data      = '0;
        req_data[8:0] = 9'h1A5;
        sb.push_back('{idx: 0, word: 9'h1A5});
        req = 4'b0001;
        tick(1'b1);
        vectors++;
        if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || ack !== 4'b0001 || m_writedata !== 32'h000001A5) begin
            miscompares++;
            $display("FAIL single_latency: cs=%b wn=%b ack=%b wd=%h, required 1,0,0001,000001a5",
                     m_chipselect, m_write_n, ack, m_writedata);
        end
        busy_cnt = busy ? 1 : 0;
        ack_cnt  = ack[0] ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (busy) busy_cnt++;
            if (ack[0]) ack_cnt++;
        end
        vectors++;
        if (busy_cnt != BUSY_LEN || ack_cnt != 1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_busy: busy_cycles=%0d ack_cycles=%0d pending=%0d, required %0d,1,0",
                     busy_cnt, ack_cnt, sb.size(), BUSY_LEN);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*LED_W +: LED_W] = 9'(9'h0C0 + 3 * i);
            sb.push_back('{idx: i, word: 9'(9'h0C0 + 3 * i)});
        end
        req = 4'b1111;
        for (int i = 0; i < 60; i++) tick(1'b1);
        vectors++;
        if (log_owner.size() != 4 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rr_count: writes=%0d pending=%0d, required 4,0", log_owner.size(), sb.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (log_owner[i] != i) begin
                    miscompares++;
                    $display("FAIL rr_order: write %0d owner=%0d, required %0d", i, log_owner[i], i);
                end
            end
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (log_cyc[i] - log_cyc[i-1] != GAP) begin
                    miscompares++;
                    $display("FAIL rr_spacing: gap %0d = %0d cycles, required %0d", i, log_cyc[i] - log_cyc[i-1], GAP);
                end
            end
        end
    endtask

    task automatic test_fairness();
        reset_dut();
        req_data[8:0]   = 9'h111;
        req_data[26:18] = 9'h122;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{idx: 0, word: 9'h111});
            sb.push_back('{idx: 2, word: 9'h122});
        end
        req = 4'b0101;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0);
            if (log_owner.size() >= 6) break;
        end
        req = '0;
        for (int i = 0; i < 12; i++) tick(1'b0);
        vectors++;
        if (log_owner.size() != 6 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL fair_count: writes=%0d pending=%0d, required 6,0", log_owner.size(), sb.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        reset_dut();
        req_data[35:27] = 9'h055;
        sb.push_back('{idx: 3, word: 9'h055});
        req = 4'b1000;
        repeat (3) tick(1'b1);
        vectors++;
        if (busy !== 1'b1 || owner !== 2'd3) begin
            miscompares++;
            $display("FAIL pre_reset: busy=%b owner=%0d, required 1,3", busy, owner);
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ack !== 4'b0 || m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_writedata !== 32'h0 ||
            busy !== 1'b0 || owner !== 2'd0 || err !== 1'b0 || m_address !== 2'b0) begin
            miscompares++;
            $display("FAIL async_reset: ack=%b cs=%b wn=%b wd=%h busy=%b owner=%0d err=%b, required 0,0,1,0,0,0,0",
                     ack, m_chipselect, m_write_n, m_writedata, busy, owner, err);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        log_owner.delete();
        log_cyc.delete();
        req_data[17:9]  = 9'h0A1;
        req_data[26:18] = 9'h0A2;
        sb.push_back('{idx: 1, word: 9'h0A1});
        sb.push_back('{idx: 2, word: 9'h0A2});
        req = 4'b0110;
        for (int i = 0; i < 30; i++) tick(1'b1);
        vectors++;
        if (log_owner.size() != 2 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_count: writes=%0d pending=%0d, required 2,0", log_owner.size(), sb.size());
        end else begin
            vectors++;
            if (log_owner[0] != 1 || log_owner[1] != 2) begin
                miscompares++;
                $display("FAIL post_reset_order: %0d,%0d, required 1,2", log_owner[0], log_owner[1]);
            end
        end
    endtask

`ifdef LEDARB_READBACK_EN
    task automatic test_readback();
        reset_dut();
        slave_broken  = 1'b0;
        req_data[8:0] = 9'h0FF;
        sb.push_back('{idx: 0, word: 9'h0FF});
        req = 4'b0001;
        for (int i = 0; i < 15; i++) tick(1'b1);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL readback_good: err=%b, required 0", err);
        end
        slave_broken   = 1'b1;
        req_data[17:9] = 9'h0FF;
        sb.push_back('{idx: 1, word: 9'h0FF});
        req = 4'b0010;
        for (int i = 0; i < 15; i++) tick(1'b1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL readback_bad: err=%b, required 1", err);
        end
        slave_broken = 1'b0;
        sb.push_back('{idx: 2, word: 9'h0FF});
        req_data[26:18] = 9'h0FF;
        req = 4'b0100;
        for (int i = 0; i < 15; i++) tick(1'b1);
        vectors++;
        if (err !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL readback_sticky: err=%b pending=%0d, required 1,0", err, sb.size());
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid_hold();
`ifdef LEDARB_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
